// File: rtl/sa_os_tile.sv
// Output-stationary systolic matmul tile: skewed operand injection, run FSM, row-serial drain.
// Optional macro SA_OS_SATURATE_EN: saturating sticky accumulators plus a sat_flag output.
module sa_os_tile #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8,
  parameter int KW    = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic [ROWS*WIDTH-1:0]   a_in,
  input  logic [COLS*WIDTH-1:0]   b_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic                    busy,
  output logic                    done
`ifdef SA_OS_SATURATE_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS+COLS);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d, beat_q, beat_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            clr_acc, mac_en, accept;

  logic signed [WIDTH-1:0] a_feed [ROWS];
  logic signed [WIDTH-1:0] b_feed [COLS];
  logic signed [WIDTH-1:0] a_pipe [ROWS][COLS];
  logic signed [WIDTH-1:0] b_pipe [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_arr [ROWS][COLS];
`ifdef SA_OS_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic sat_arr [ROWS][COLS];
`endif

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_row   = row_q;
  assign accept    = in_valid && in_ready;
  assign mac_en    = (state_q == LOAD) || (state_q == FLUSH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clr_acc = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        k_d     = k_len;
        beat_d  = '0;
        flush_d = '0;
        row_d   = '0;
        clr_acc = 1'b1;
        state_d = (k_len == '0) ? DRAIN : LOAD;
      end
      LOAD: if (accept) begin
        beat_d = beat_q + KW'(1);
        if (beat_q + KW'(1) == k_q) state_d = FLUSH;
      end
      FLUSH: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(ROWS+COLS-2)) state_d = DRAIN;
      end
      DRAIN: if (out_ready) begin
        if (row_q == RW'(ROWS-1)) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle/gap cycles inject zeros so bubbles contribute nothing to the sums.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic signed [WIDTH-1:0] inj;
    assign inj = accept ? a_in[i*WIDTH +: WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_feed[i] = inj;
    end else begin : g_delay
      logic signed [WIDTH-1:0] sh_q [i];
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sh_q <= '{default: '0};
        else begin
          sh_q[0] <= inj;
          for (int unsigned s = 1; s < i; s++) sh_q[s] <= sh_q[s-1];
        end
      end
      assign a_feed[i] = sh_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    logic signed [WIDTH-1:0] inj;
    assign inj = accept ? b_in[j*WIDTH +: WIDTH] : '0;
    if (j == 0) begin : g_direct
      assign b_feed[j] = inj;
    end else begin : g_delay
      logic signed [WIDTH-1:0] sh_q [j];
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sh_q <= '{default: '0};
        else begin
          sh_q[0] <= inj;
          for (int unsigned s = 1; s < j; s++) sh_q[s] <= sh_q[s-1];
        end
      end
      assign b_feed[j] = sh_q[j-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [WIDTH-1:0]   a_q, b_q, a_west, b_north;
      logic signed [2*WIDTH-1:0] prod;
      logic signed [ACC_W-1:0]   acc_q, acc_d;
      if (c == 0) begin : g_aw
        assign a_west = a_feed[r];
      end else begin : g_ai
        assign a_west = a_pipe[r][c-1];
      end
      if (r == 0) begin : g_bn
        assign b_north = b_feed[c];
      end else begin : g_bi
        assign b_north = b_pipe[r-1][c];
      end
      assign prod = a_q * b_q;
`ifdef SA_OS_SATURATE_EN
      logic sat_q, sat_d;
      logic signed [ACC_W:0] sum;
      always_comb begin
        sum   = $signed({acc_q[ACC_W-1], acc_q}) + (ACC_W+1)'(prod);
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_acc) begin
          acc_d = '0;
          sat_d = 1'b0;
        end else if (mac_en && !sat_q) begin
          if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
        end
      end
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sat_q <= 1'b0;
        else      sat_q <= sat_d;
      end
      assign sat_arr[r][c] = sat_q;
`else
      always_comb begin
        acc_d = acc_q;
        if (clr_acc)     acc_d = '0;
        else if (mac_en) acc_d = acc_q + ACC_W'(prod);
      end
`endif
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_west;
          b_q   <= b_north;
          acc_q <= acc_d;
        end
      end
      assign a_pipe[r][c]  = a_q;
      assign b_pipe[r][c]  = b_q;
      assign acc_arr[r][c] = acc_q;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid)
      for (int unsigned c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] = acc_arr[row_q][c];
  end

`ifdef SA_OS_SATURATE_EN
  always_comb begin
    sat_flag = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++) sat_flag = sat_flag | sat_arr[r][c];
  end
`endif

endmodule

// File: tb/tb_sa_os_tile.sv
// Directed bench for sa_os_tile: 4x4 tile at ACC_W=24, plus an ACC_W=16 copy for overflow behaviour.
module tb_sa_os_tile;
  localparam int R = 4, C = 4, W = 8, AW = 24, AW16 = 16, KW = 10;

  logic CLK = 1'b0, RST = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic [R*W-1:0]  a_in = '0;
  logic [C*W-1:0]  b_in = '0;
  logic            in_ready, out_valid, busy, done;
  logic [C*AW-1:0] out_data;
  logic [1:0]      out_row;
  logic            in_ready16, out_valid16, busy16, done16;
  logic [C*AW16-1:0] out_data16;
  logic [1:0]      out_row16;
`ifdef SA_OS_SATURATE_EN
  logic sat24, sat16;
`endif

  sa_os_tile #(.ROWS(R), .COLS(C), .WIDTH(W), .ACC_W(AW), .KW(KW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .busy(busy), .done(done)
`ifdef SA_OS_SATURATE_EN
    , .sat_flag(sat24)
`endif
  );

  sa_os_tile #(.ROWS(R), .COLS(C), .WIDTH(W), .ACC_W(AW16), .KW(KW)) dut16 (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready16), .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_row(out_row16), .busy(busy16), .done(done16)
`ifdef SA_OS_SATURATE_EN
    , .sat_flag(sat16)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [KW-1:0]         k;
    logic [7:0]            vpat;    // in_valid per slot, LSB first; 1 beyond slot 7
    logic                  stall;   // hold out_ready low on row 1, pulse start meanwhile
    logic                  chk16;
    logic                  chksat0;
    logic [15:0]           exp16;
    logic [3:0][3:0][7:0]  a;
    logic [3:0][3:0][7:0]  b;
    logic [3:0][3:0][23:0] exp;
  } vec_t;

  vec_t vt [7];
  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0][3:0][23:0] uni(input int v);
    logic [3:0][3:0][23:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[r][c] = 24'(v);
    return res;
  endfunction

  function automatic logic [3:0][3:0][23:0] mm(input logic [3:0][3:0][7:0] a,
                                               input logic [3:0][3:0][7:0] b, input int k);
    logic [3:0][3:0][23:0] res;
    int s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int t = 0; t < k; t++) s += $signed(a[t][r]) * $signed(b[t][c]);
        res[r][c] = 24'(s);
      end
    return res;
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    int acc_n, slot, lat, n, exp_lat;
    logic rdy_ok;
    start = 1'b1;
    k_len = v.k;
    tick();
    start = 1'b0;
    lat = 1;
    acc_n = 0;
    slot = 0;
    rdy_ok = 1'b1;
    while (acc_n < int'(v.k) && slot < 64) begin
      in_valid = (slot < 8) ? v.vpat[slot] : 1'b1;
      if (in_valid) begin
        a_in = v.a[acc_n];
        b_in = v.b[acc_n];
        acc_n++;
      end else begin
        a_in = $urandom;
        b_in = $urandom;
      end
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      tick();
      lat++;
      slot++;
    end
    in_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    if (v.k != 0) chk({tag, "_in_ready_load"}, rdy_ok, 1);
    chk({tag, "_in_ready_drop"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      lat++;
      n++;
    end
    chk({tag, "_out_valid_wait"}, out_valid, 1);
    exp_lat = (v.k == 0) ? 1 : slot + R + C;
    chk({tag, "_latency"}, lat, exp_lat);
    out_ready = 1'b1;
    for (int r = 0; r < R; r++) begin
      if (v.stall && r == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          start = (s == 2);
          k_len = 5;
          chk($sformatf("%s_stall_row%0d", tag, s), {out_valid, out_row}, {1'b1, 2'd1});
          chk($sformatf("%s_stall_data%0d", tag, s), out_data, v.exp[1]);
          tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
      end
      chk($sformatf("%s_row%0d_idx", tag, r), {out_valid, out_row}, {1'b1, r[1:0]});
      chk($sformatf("%s_row%0d_data", tag, r), out_data, v.exp[r]);
      if (v.chk16) begin
        chk($sformatf("%s_row%0d_data16", tag, r), out_data16, {4{v.exp16}});
        chk($sformatf("%s_row%0d_idx16", tag, r), {out_valid16, out_row16}, {1'b1, r[1:0]});
`ifdef SA_OS_SATURATE_EN
        chk($sformatf("%s_row%0d_sat16", tag, r), sat16, 1);
`endif
      end
`ifdef SA_OS_SATURATE_EN
      if (r == 0) chk({tag, "_sat24"}, sat24, 0);
      if (v.chksat0 && r == 0) chk({tag, "_sat16_clr"}, sat16, 0);
`endif
      tick();
    end
    chk({tag, "_done_pulse"}, {done, busy, out_valid}, 3'b100);
    tick();
    chk({tag, "_done_clear"}, {done, busy, out_valid}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 7; i++) vt[i] = '0;
    vt[0].k = 1; vt[0].vpat = 8'hFF;
    vt[0].a[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    vt[0].b[0] = {8'd8, 8'd7, 8'd6, 8'd5};
    vt[0].exp[0] = {24'd8,  24'd7,  24'd6,  24'd5};
    vt[0].exp[1] = {24'd16, 24'd14, 24'd12, 24'd10};
    vt[0].exp[2] = {24'd24, 24'd21, 24'd18, 24'd15};
    vt[0].exp[3] = {24'd32, 24'd28, 24'd24, 24'd20};
    vt[1].k = 3; vt[1].vpat = 8'hFF;
    vt[2].k = 3; vt[2].vpat = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      vt[1].a[t] = {4{8'h80}}; vt[1].b[t] = {4{8'h80}};
      vt[2].a[t] = {4{8'h80}}; vt[2].b[t] = {4{8'h7F}};
    end
    vt[1].exp = uni(49152);
    vt[2].exp = uni(-48768);
    vt[3].k = 4; vt[3].vpat = 8'hE9;
    for (int t = 0; t < 4; t++) begin
      vt[3].a[t] = $urandom;
      vt[3].b[t] = $urandom;
    end
    vt[3].exp = mm(vt[3].a, vt[3].b, 4);
    vt[4].k = 0; vt[4].vpat = 8'hFF;
    vt[4].a[0] = $urandom; vt[4].b[0] = $urandom;
    vt[5].k = 4; vt[5].vpat = 8'hFF; vt[5].chk16 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      vt[5].a[t] = {4{8'h7F}}; vt[5].b[t] = {4{8'h7F}};
    end
    vt[5].exp = uni(64516);
`ifdef SA_OS_SATURATE_EN
    vt[5].exp16 = 16'h7FFF;
`else
    vt[5].exp16 = 16'(-1020);
`endif
    vt[6] = vt[0];
    vt[6].stall = 1'b1;
    vt[6].chksat0 = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outs", {in_ready, out_valid, out_data, out_row, busy, done}, '0);
    chk("reset_outs16", {in_ready16, out_valid16, out_data16, out_row16, busy16, done16}, '0);
    RST = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_case(vt[i], $sformatf("c%0d", i));

    // Abort a run with operands still in flight, then confirm a clean rerun.
    start = 1'b1; k_len = 4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a_in = 32'h05050505; b_in = 32'h07070707;
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rst_mid_outs", {in_ready, out_valid, out_data, out_row, busy, done}, '0);
    in_valid = 1'b0;
    #2;
    RST = 1'b1;
    tick();
    chk("rst_mid_idle", {busy, in_ready}, 2'b00);
    run_case(vt[0], "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
